// File: rtl/eh2_ram_ctl.sv
// Initiator-side controller for the single-port eh2 RAM macros: optional array clear after reset,
// then valid/ready read/write requests with an in-order read response channel.
module eh2_ram_ctl #(
    parameter int unsigned      DEPTH    = 4096,
    parameter int unsigned      WIDTH    = 39,
    parameter bit               INIT_EN  = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    input  logic [WIDTH-1:0]         req_wmask,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     init_done,
    output logic [$clog2(DEPTH)-1:0] ADR,
    output logic [WIDTH-1:0]         D,
    output logic [WIDTH-1:0]         WEM,
    output logic                     WE,
    output logic                     ME,
    input  logic [WIDTH-1:0]         Q
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [AW-1:0]  cnt;
    logic           rd_pend;
    logic [WIDTH-1:0] fifo_mem [2];
    logic           fifo_wp;
    logic           fifo_rp;
    logic [1:0]     count;
    logic           credit_ok;
    logic           accept;
    logic           bypass;
    logic           push;
    logic           pop;

    // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
    always_ff @(posedge CLK) begin
        if (RST) state <= INIT_EN ? INIT : RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == LAST_ADDR) state_nxt = RUN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == INIT) cnt <= cnt + AW'(1);
            init_done <= (state == RUN) || (state == INIT && cnt == LAST_ADDR);
        end
    end

    // Outstanding reads (buffered plus the one whose Q is on the bus) are capped at two.
    assign credit_ok = ({1'b0, count} + {2'b00, rd_pend}) < 3'd2;
    assign req_ready = !RST && (state == RUN) && credit_ok;
    assign accept    = req_valid && req_ready;

    assign bypass    = (count == 2'd0);
    assign rsp_valid = !RST && (rd_pend || !bypass);
    assign rsp_rdata = bypass ? Q : fifo_mem[fifo_rp];
    assign push      = rd_pend && !(bypass && rsp_ready);
    assign pop       = !bypass && rsp_valid && rsp_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pend <= 1'b0;
            fifo_wp <= 1'b0;
            fifo_rp <= 1'b0;
            count   <= 2'd0;
        end else begin
            rd_pend <= accept && !req_write;
            if (push) fifo_wp <= !fifo_wp;
            if (pop)  fifo_rp <= !fifo_rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: buffer storage is deliberately not reset; count alone says which entries are live.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[fifo_wp] <= Q;
    end

    always_ff @(posedge CLK) begin
        if (!RST) assert (!(push && !pop && count == 2'd2));
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        ME  = 1'b0;
        WE  = 1'b0;
        ADR = req_addr;
        D   = req_wdata;
        WEM = req_wmask;
        if (!RST) begin
            if (state == INIT) begin
                ME  = 1'b1;
                WE  = 1'b1;
                ADR = cnt;
                D   = INIT_VAL;
                WEM = '1;
            end else if (accept) begin
                ME = 1'b1;
                WE = req_write;
            end
        end
    end

endmodule

// File: tb/tb_eh2_ram_ctl.sv
// Directed bench for eh2_ram_ctl: request-level memory/queue model checked every cycle, plus literal spot checks.
module tb_eh2_ram_ctl;

    localparam int DEPTH = 64;
    localparam int WIDTH = 39;
    localparam logic [WIDTH-1:0] IVAL = 39'h5A;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [5:0]       req_addr = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic [WIDTH-1:0] req_wmask = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_rdata;
    logic             init_done;
    logic [5:0]       ADR;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] WEM;
    logic             WE;
    logic             ME;
    logic [WIDTH-1:0] Q = '0;

    eh2_ram_ctl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_EN(1'b1), .INIT_VAL(IVAL)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .ADR(ADR), .D(D), .WEM(WEM), .WE(WE), .ME(ME), .Q(Q)
    );

    always #5 CLK = ~CLK;

    // Single-port RAM macro with bit write mask and one-cycle read latency.
    logic [WIDTH-1:0] ram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram[i] = 39'h0DEADBEEF + WIDTH'(i);
    always @(posedge CLK) begin
        if (ME) begin
            if (WE) ram[ADR] <= (ram[ADR] & ~WEM) | (D & WEM);
            else    Q <= ram[ADR];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request-level model: memory contents in request order, queue of reads awaiting delivery.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] got_q [$];
    int               got_cyc [$];
    int               k = 0;
    int               cyc = 0;

    always @(negedge CLK) begin
        int sz;
        cyc++;
        if (RST) begin
            check("rst_me", ME, 0);
            check("rst_we", WE, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            k = 0;
            exp_q.delete();
        end else if (k < DEPTH) begin
            check("init_me", ME, 1);
            check("init_we", WE, 1);
            check("init_adr", ADR, 64'(k));
            check("init_d", D, IVAL);
            check("init_wem", WEM, {WIDTH{1'b1}});
            check("init_done_low", init_done, 0);
            check("init_req_ready", req_ready, 0);
            check("init_rsp_valid", rsp_valid, 0);
            k++;
            if (k == DEPTH) for (int i = 0; i < DEPTH; i++) ref_mem[i] = IVAL;
        end else begin
            sz = exp_q.size();
            check("run_init_done", init_done, 1);
            check("run_req_ready", req_ready, sz < 2);
            check("run_rsp_valid", rsp_valid, sz != 0);
            if (rsp_valid && sz != 0) begin
                check("rsp_rdata", rsp_rdata, exp_q[0]);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    got_q.push_back(rsp_rdata);
                    got_cyc.push_back(cyc);
                end
            end
            if (req_valid && req_ready) begin
                check("acc_me", ME, 1);
                check("acc_we", WE, req_write);
                check("acc_adr", ADR, req_addr);
                if (req_write) begin
                    check("acc_d", D, req_wdata);
                    check("acc_wem", WEM, req_wmask);
                    ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end else begin
                check("idle_me", ME, 0);
                check("idle_we", WE, 0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_req(input bit wr, input int addr, input logic [WIDTH-1:0] wd,
                          input logic [WIDTH-1:0] wm);
        bit acc = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = 6'(addr);
        req_wdata = wd;
        req_wmask = wm;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge CLK);
            acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        check("req_accepted", acc, 1);
    endtask

    task automatic wait_rsp(input int n);
        for (int t = 0; t < 100 && got_q.size() < n; t++) @(negedge CLK);
        check("rsp_arrived", got_q.size() >= n, 1);
    endtask

    task automatic read_one(input string name, input int addr, input logic [WIDTH-1:0] exp);
        got_q.delete();
        do_req(1'b0, addr, '0, '0);
        wait_rsp(1);
        check(name, got_q[0], exp);
    endtask

    task automatic measure_init();
        int n = 0;
        @(negedge CLK);
        check("init_first_adr", ADR, 0);
        while (!init_done && n < 200) begin
            n++;
            @(negedge CLK);
        end
        check("init_length", n, 64);
        check("ready_after_init", req_ready, 1);
        tick();
    endtask

    logic [WIDTH-1:0] ones = {WIDTH{1'b1}};

    initial begin
        int acc;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        measure_init();

        read_one("init_val_17", 17, 39'h5A);

        got_q.delete();
        do_req(1'b1, 3, 39'h1234, ones);
        do_req(1'b0, 3, '0, '0);
        wait_rsp(1);
        check("raw_3", got_q[0], 39'h1234);

        do_req(1'b1, 5, 39'h00FF, ones);
        do_req(1'b1, 5, 39'hAB00, 39'hFF00);
        read_one("partial_5", 5, 39'hABFF);

        // Backpressure: three reads queued with the consumer stalled.
        do_req(1'b1, 1, 39'h111, ones);
        do_req(1'b1, 2, 39'h222, ones);
        do_req(1'b1, 3, 39'h333, ones);
        got_q.delete();
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 6'd1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (req_ready) acc++;
            tick();
            req_addr = 6'(1 + acc);
        end
        check("bp_accepts", acc, 2);
        @(negedge CLK);
        check("bp_ready_low", req_ready, 0);
        tick();
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && acc < 3; n++) begin
            @(negedge CLK);
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        check("bp_third_accept", acc, 3);
        wait_rsp(3);
        check("bp_order_0", got_q[0], 39'h111);
        check("bp_order_1", got_q[1], 39'h222);
        check("bp_order_2", got_q[2], 39'h333);

        // Streaming: 16 back-to-back reads with the consumer always ready.
        for (int i = 0; i < 16; i++) do_req(1'b1, 40 + i, 39'h1000 + WIDTH'(i), ones);
        got_q.delete();
        got_cyc.delete();
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_addr = 6'(40 + i);
            @(negedge CLK);
            check("stream_ready", req_ready, 1);
            tick();
        end
        req_valid = 1'b0;
        wait_rsp(16);
        for (int i = 0; i < 16; i++) check("stream_data", got_q[i], 39'h1000 + WIDTH'(i));
        for (int i = 1; i < 16; i++) check("stream_gap", got_cyc[i] - got_cyc[i-1], 1);

        // Reset mid-init at cnt=30: init must restart from address 0.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("pre_rst_adr30", ADR, 30);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        measure_init();
        read_one("reinit_3", 3, 39'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eh2_ram_ctl.md
Name: eh2_ram_ctl

Overview:
Initiator-side controller for the single-port eh2 RAM macros (ram_<depth>x<width> / ram_be_<depth>x<width>). It drives ADR/D/WEM/WE/ME and captures Q. After reset it optionally clears the whole array. It then accepts valid/ready read/write requests and returns read data on a valid/ready response channel, with a 2-entry skid buffer absorbing the RAM's fixed 1-cycle read latency. It sits between ICCM/DCCM/cache-tag logic and the RAM instance.

Parameters:
DEPTH, 4096, RAM entries; power of 2, >= 32.
WIDTH, 39, RAM data width.
INIT_EN, 1, 1 = clear array after reset; 0 = skip init.
INIT_VAL, 0, WIDTH-bit value written to every entry during init.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous reset, active-high.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when valid & ready.
req_write  in  1  1 = write, 0 = read.
req_addr  in  $clog2(DEPTH)  address.
req_wdata  in  WIDTH  write data.
req_wmask  in  WIDTH  per-bit write enable (1 = write the bit).
rsp_valid  out  1  read data valid.
rsp_ready  in  1  consumer ready.
rsp_rdata  out  WIDTH  read data.
init_done  out  1  high once init is complete; stays high until RST.
ADR  out  $clog2(DEPTH)  RAM address.
D  out  WIDTH  RAM write data.
WEM  out  WIDTH  RAM bit write mask. Tie off (unused) for non-BE macros.
WE  out  1  RAM write enable.
ME  out  1  RAM memory enable.
Q  in  WIDTH  RAM read data. Valid in the cycle after an ME & ~WE edge.

Behaviour:
- While RST=1 at an edge, the following clear: state -> INIT (or RUN if INIT_EN=0), init counter -> 0, rd_pend -> 0, FIFO count -> 0, init_done -> 0. Outputs with RST=1: req_ready=0, rsp_valid=0, ME=0, WE=0.
- Reset is honoured mid-init and mid-traffic. In-flight reads and buffered responses are discarded. Init restarts from address 0.
- States:
  - INIT: each cycle drives ME=1, WE=1, ADR=cnt, D=INIT_VAL, WEM=all ones. req_ready=0. cnt increments each cycle. At cnt=DEPTH-1 the state goes to RUN and init_done=1 from the next cycle. Init takes exactly DEPTH cycles.
  - RUN: stays in RUN until RST.
- INIT_EN=0: init_done=1 in the first cycle after RST deasserts.
- req_ready = RUN & ((count + rd_pend) < 2). It is independent of req_valid and the request payload.
- Accept (RUN & req_valid & req_ready) drives, combinationally in the same cycle: ME=1, WE=req_write, ADR=req_addr, D=req_wdata, WEM=req_wmask. With no accept, ME=0 and WE=0.
- Write: no response is generated. Bits with WEM=0 are preserved by the RAM.
- Read: rd_pend=1 in the next cycle, and Q is valid in that cycle.
  - If count=0 in that cycle, bypass: rsp_valid=1, rsp_rdata=Q. If rsp_ready=0, Q is pushed into the FIFO.
  - If count>0, Q is pushed and rsp_rdata comes from the FIFO head.
  - Minimum read latency: accept at cycle N -> rsp_valid at N+1.
- Ordering: responses are returned strictly in request order. A read after a write to the same address (issued in a later cycle) returns the new data.
- FIFO: 2 entries, with a pop on rsp_valid & rsp_ready. Push and pop may occur in the same cycle; count is then unchanged. The credit rule guarantees no overflow; an overflow is an assertion failure.
- Throughput:
  - Back-to-back reads at 1/cycle are sustained while rsp_ready=1.
  - With rsp_ready=0, at most 2 reads are outstanding; after that req_ready=0.
- rsp_rdata is don't-care while rsp_valid=0. rsp_valid & rsp_rdata hold stable until accepted.

Test Plan:
- DEPTH=64, INIT_EN=1, INIT_VAL=0x5A:
  - Release RST -> exactly 64 cycles of ME=WE=1 with ADR 0..63, then init_done=1 and req_ready=1.
  - A read of addr 17 then returns 0x5A.
- Write addr 3 = 0x1234 (mask all ones), then read addr 3 in the next cycle -> rsp_valid at accept+1 with rsp_rdata=0x1234.
- Partial write:
  - Preload addr 5 = 0x00FF.
  - Write 0xAB00 with mask 0xFF00.
  - Read addr 5 -> 0xABFF.
- Backpressure:
  - With rsp_ready=0, issue reads to addrs 1, 2, 3 -> only 2 are accepted and req_ready=0.
  - Then raise rsp_ready -> data returns in order 1, 2, and the third read is accepted.
- Streaming: 16 consecutive reads with rsp_ready=1 -> one accept per cycle, and 16 responses in order on consecutive cycles.
- Assert RST at init cnt=30 for one cycle -> ME=0 during reset, then init restarts at ADR=0 and init_done rises 64 cycles after release.
